// File: rtl/mem_sweep_reader.sv
// Sweeps every address of a small read-latency memory after unlock, holding each
// returned byte with its address on the display outputs for a fixed dwell time.
module mem_sweep_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DWELL  = 50000000,
  parameter int RD_LAT = 1,
  parameter int LOOP   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              o_unlock,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW_W-1:0]  DWELL_TC = DW_W'(DWELL - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHOW,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync2_q, sync_prev_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic                done_q, done_d;

  logic start_edge;
  logic last_addr;

  assign start_edge = sync2_q & ~sync_prev_q;
  assign last_addr  = &addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_prev_q <= 1'b0;
    end else begin
      sync1_q     <= start;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      dwell_q      <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      dwell_q      <= dwell_d;
      disp_addr_q  <= disp_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    dwell_d      = dwell_q;
    disp_addr_d  = disp_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = disp_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge && o_unlock) begin
          addr_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        lat_d   = LAT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          disp_data_d  = mem_data;
          disp_addr_d  = addr_q;
          disp_valid_d = 1'b1;
          dwell_d      = '0;
          state_d      = S_SHOW;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_SHOW: begin
        if (!pause) begin
          if (dwell_q == DWELL_TC) begin
            if (!last_addr) begin
              addr_d  = addr_q + 1'b1;
              state_d = S_REQ;
            end else if (LOOP != 0) begin
              addr_d  = '0;
              done_d  = 1'b1;
              state_d = S_REQ;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lock loss overrides everything, including a coincident dwell expiry.
    if ((state_q != S_IDLE) && !o_unlock) begin
      state_d      = S_IDLE;
      addr_d       = addr_q;
      disp_addr_d  = '0;
      disp_data_d  = '0;
      disp_valid_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd_en  = (state_q == S_REQ);
  assign busy       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_SHOW);
  assign done       = done_q;
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_mem_sweep_reader.sv
// Directed bench for mem_sweep_reader: one stop-at-end and one looping instance
// share stimulus and a preloaded memory image mem[i] = A0+i.
module tb_mem_sweep_reader;

  logic       clk;
  logic       rst;
  logic       o_unlock;
  logic       start;
  logic       pause;

  logic [3:0] addr0, addr1, daddr0, daddr1;
  logic [7:0] mdata0, mdata1, ddata0, ddata1;
  logic       rd_en0, rd_en1, dvalid0, dvalid1, busy0, busy1, done0, done1;

  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;
  int done0_cnt = 0;
  int strobe0_cnt = 0;

  mem_sweep_reader #(.ADDR_W(4), .DATA_W(8), .DWELL(4), .RD_LAT(1), .LOOP(0)) u_dut0 (
    .clk(clk), .rst(rst), .o_unlock(o_unlock), .start(start), .pause(pause),
    .mem_addr(addr0), .mem_rd_en(rd_en0), .mem_data(mdata0),
    .disp_addr(daddr0), .disp_data(ddata0), .disp_valid(dvalid0),
    .busy(busy0), .done(done0)
  );

  mem_sweep_reader #(.ADDR_W(4), .DATA_W(8), .DWELL(4), .RD_LAT(1), .LOOP(1)) u_dut1 (
    .clk(clk), .rst(rst), .o_unlock(o_unlock), .start(start), .pause(pause),
    .mem_addr(addr1), .mem_rd_en(rd_en1), .mem_data(mdata1),
    .disp_addr(daddr1), .disp_data(ddata1), .disp_valid(dvalid1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
  end

  always @(posedge clk) begin
    if (rd_en0) mdata0 <= mem[addr0];
    if (rd_en1) mdata1 <= mem[addr1];
  end

  always @(negedge clk) begin
    if (rst && done0) done0_cnt++;
    if (rst && rd_en0) strobe0_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe0(input string tag, input logic [3:0] a, input int budget);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rd_en0 && addr0 == a) begin
        hit = 1'b1;
        break;
      end
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d;
    logic seen, hold_ok;

    rst = 1'b0; o_unlock = 1'b0; start = 1'b0; pause = 1'b0;
    step(1);
    chk("rst_rd_en", 32'(rd_en0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_disp_valid", 32'(dvalid0), 0);
    chk("rst_disp_data", 32'(ddata0), 0);
    chk("rst_mem_addr", 32'(addr0), 0);
    step(1);
    rst = 1'b1;
    step(2);

    // Start while locked must be ignored.
    start = 1'b1;
    s = strobe0_cnt;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy0 || busy1 || rd_en1) seen = 1'b1;
    end
    chk("locked_strobes", 32'(strobe0_cnt - s), 0);
    chk("locked_busy", 32'(seen), 0);
    start = 1'b0;
    o_unlock = 1'b1;
    step(3);
    chk("unlock_no_autostart", 32'(busy0), 0);

    // Full sweep; start edge latency to first strobe.
    d = done0_cnt;
    start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("strobe_early", 32'(rd_en0), 0);
    @(posedge clk); #1;
    chk("first_strobe", 32'(rd_en0), 1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("sweep_strobe", 32'(rd_en0), 1);
      chk("sweep_addr", 32'(addr0), 32'(i));
      chk("sweep_busy", 32'(busy0), 1);
      chk("loop_addr", 32'(addr1), 32'(i));
      if (i == 7) start = 1'b0;
      if (i == 9) start = 1'b1;
      step(1);
      chk("strobe_one_cycle", 32'(rd_en0), 0);
      step(1);
      chk("disp_data", 32'(ddata0), 32'h0A0 + 32'(i));
      chk("disp_addr", 32'(daddr0), 32'(i));
      chk("disp_valid", 32'(dvalid0), 1);
      step(4);
    end
    chk("done_pulse", 32'(done0), 1);
    chk("done_busy", 32'(busy0), 0);
    chk("loop_done", 32'(done1), 1);
    chk("loop_wrap_strobe", 32'(rd_en1), 1);
    chk("loop_wrap_addr", 32'(addr1), 0);
    step(1);
    chk("done_one_cycle", 32'(done0), 0);
    chk("end_busy", 32'(busy0), 0);
    chk("end_disp_valid", 32'(dvalid0), 1);
    chk("end_disp_addr", 32'(daddr0), 15);
    chk("end_disp_data", 32'(ddata0), 32'hAF);
    chk("done_count", 32'(done0_cnt - d), 1);
    step(10);
    chk("stays_idle", 32'(busy0), 0);

    // Lock loss at address 5.
    start = 1'b0;
    step(3);
    start = 1'b1;
    wait_strobe0("restart_a0", 4'd0, 6);
    wait_strobe0("reach_a5", 4'd5, 40);
    step(2);
    chk("pre_lock_disp", 32'(ddata0), 32'hA5);
    d = done0_cnt;
    s = strobe0_cnt;
    o_unlock = 1'b0;
    step(1);
    chk("lock_disp_valid", 32'(dvalid0), 0);
    chk("lock_disp_data", 32'(ddata0), 0);
    chk("lock_disp_addr", 32'(daddr0), 0);
    chk("lock_busy", 32'(busy0), 0);
    chk("lock_loop_busy", 32'(busy1), 0);
    step(10);
    chk("lock_no_strobe", 32'(strobe0_cnt - s), 0);
    chk("lock_no_done", 32'(done0_cnt - d), 0);

    o_unlock = 1'b1;
    start = 1'b0;
    step(3);
    start = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("relock_strobe", 32'(rd_en0), 1);
    chk("relock_addr", 32'(addr0), 0);

    // Pause 20 cycles during SHOW at address 3.
    wait_strobe0("reach_a3", 4'd3, 30);
    step(2);
    chk("pause_start_data", 32'(ddata0), 32'hA3);
    pause = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (ddata0 !== 8'hA3 || rd_en0 !== 1'b0) hold_ok = 1'b0;
    end
    pause = 1'b0;
    chk("pause_hold", 32'(hold_ok), 1);
    step(3);
    chk("pause_tail_no_strobe", 32'(rd_en0), 0);
    chk("pause_tail_data", 32'(ddata0), 32'hA3);
    step(1);
    chk("after_pause_strobe", 32'(rd_en0), 1);
    chk("after_pause_addr", 32'(addr0), 4);

    // Asynchronous reset in WAIT.
    step(1);
    rst = 1'b0;
    #1;
    chk("arst_rd_en", 32'(rd_en0), 0);
    chk("arst_busy", 32'(busy0), 0);
    chk("arst_disp_valid", 32'(dvalid0), 0);
    chk("arst_disp_data", 32'(ddata0), 0);
    chk("arst_disp_addr", 32'(daddr0), 0);
    chk("arst_mem_addr", 32'(addr0), 0);
    chk("arst_done", 32'(done0), 0);
    start = 1'b0;
    step(2);
    rst = 1'b1;
    s = strobe0_cnt;
    step(20);
    chk("post_rst_no_strobe", 32'(strobe0_cnt - s), 0);
    chk("post_rst_busy", 32'(busy0), 0);
    start = 1'b1;
    wait_strobe0("post_rst_start", 4'd0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
